// File: rtl/layer_seq_pkg.sv
// Purpose : shared types for the layer sequencer: FSM state encoding and per-state control vectors.
// Latency : n/a (types and constants only).
// Backpressure: n/a. Optional bias states exist only when LAYER_SEQ_BIAS_EN is defined.
package layer_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLEAR,
`ifdef LAYER_SEQ_BIAS_EN
        S_BIAS,
        S_BIAS_ACC,
`endif
        S_FETCH,
        S_ACC,
        S_ACT,
        S_WRITE,
        S_DONE
    } state_t;

    // Control strobes decoded from the current state.
    typedef struct packed {
        logic mem_req;
        logic alu_rst;
        logic alu_en;
        logic act_en;
        logic bias_sel;
        logic out_we;
        logic busy;
        logic done;
    } ctrl_t;

    //                                      req rst en act bs we busy done
    localparam ctrl_t CTRL_IDLE     = ctrl_t'(8'b0___0___0__0___0__0__0____0);
    localparam ctrl_t CTRL_CLEAR    = ctrl_t'(8'b0___1___0__0___0__0__1____0);
    localparam ctrl_t CTRL_BIAS     = ctrl_t'(8'b1___0___0__0___1__0__1____0);
    localparam ctrl_t CTRL_BIAS_ACC = ctrl_t'(8'b0___0___1__0___1__0__1____0);
    localparam ctrl_t CTRL_FETCH    = ctrl_t'(8'b1___0___0__0___0__0__1____0);
    localparam ctrl_t CTRL_ACC      = ctrl_t'(8'b0___0___1__0___0__0__1____0);
    localparam ctrl_t CTRL_ACT      = ctrl_t'(8'b0___0___0__1___0__0__1____0);
    localparam ctrl_t CTRL_WRITE    = ctrl_t'(8'b0___0___0__0___0__1__1____0);
    localparam ctrl_t CTRL_DONE     = ctrl_t'(8'b0___0___0__0___0__0__0____1);

endpackage

// File: rtl/layer_sequencer_wrap_counter.sv
// Purpose : modulo-MODULUS up counter with synchronous clear, increment and terminal-count flag.
// Latency : count updates on the clock edge after clr_i/inc_i; tc_o is combinational from the count.
// Backpressure: none; clr_i has priority over inc_i.
// Ports: clk, rst (async active-high), clr_i, inc_i -> cnt_o (count), tc_o (count == MODULUS-1).
module wrap_counter #(
    parameter int MODULUS = 8,
    parameter int W       = $clog2(MODULUS)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);
    localparam logic [W-1:0] LAST = W'(MODULUS - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tc_o  = (cnt_q == LAST);
    assign cnt_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = tc_o ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/layer_sequencer.sv
// Purpose : sequences one neural-network layer pass: per neuron clear, (optional bias), N_INPUTS fetch/accumulate, activate, write.
// Latency : 2*N_INPUTS+3 cycles per neuron with mem_ready held high (+2 with bias); done pulses one cycle after the last write.
// Backpressure: FETCH/BIAS hold until mem_ready; abort restarts the current neuron; start is only honoured in IDLE.
// Ports: clk, reset (async active-high), start, abort, mem_ready -> mem_req, w_addr, x_addr, alu_rst, alu_en,
//        act_en, bias_sel, out_we, out_addr, busy, done. All outputs are decoded from registered state/counters.
// Build option: define LAYER_SEQ_BIAS_EN to add the BIAS/BIAS_ACC states (bias word at N_INPUTS*N_NEURONS+n).
module layer_sequencer
    import layer_seq_pkg::*;
#(
    parameter int N_INPUTS  = 8,
    parameter int N_NEURONS = 4,
    parameter int ADDR_W    = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          abort,
    input  logic                          mem_ready,
    output logic                          mem_req,
    output logic [ADDR_W-1:0]             w_addr,
    output logic [$clog2(N_INPUTS)-1:0]   x_addr,
    output logic                          alu_rst,
    output logic                          alu_en,
    output logic                          act_en,
    output logic                          bias_sel,
    output logic                          out_we,
    output logic [$clog2(N_NEURONS)-1:0]  out_addr,
    output logic                          busy,
    output logic                          done
);
    localparam int IW = $clog2(N_INPUTS);
    localparam int NW = $clog2(N_NEURONS);
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(N_INPUTS);
`ifdef LAYER_SEQ_BIAS_EN
    localparam logic [ADDR_W-1:0] BIAS_BASE = ADDR_W'(N_INPUTS * N_NEURONS);
`endif

    state_t        state_q;
    logic [IW-1:0] i_cnt;
    logic [NW-1:0] n_cnt;
    logic          i_tc;
    logic          n_tc;
    logic          abort_hit;
    logic          i_clr;
    logic          i_inc;
    logic          n_clr;
    logic          n_inc;
    ctrl_t         ctrl;

    // Abort only matters while a neuron's partial sum is being built.
    always_comb begin
        abort_hit = 1'b0;
        case (state_q)
            S_FETCH, S_ACC, S_ACT: abort_hit = abort;
`ifdef LAYER_SEQ_BIAS_EN
            S_BIAS, S_BIAS_ACC:    abort_hit = abort;
`endif
            default:               abort_hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else if (abort_hit) begin
            state_q <= S_CLEAR;
        end else begin
            case (state_q)
                S_IDLE:     if (start) state_q <= S_CLEAR;
`ifdef LAYER_SEQ_BIAS_EN
                S_CLEAR:    state_q <= S_BIAS;
                S_BIAS:     if (mem_ready) state_q <= S_BIAS_ACC;
                S_BIAS_ACC: state_q <= S_FETCH;
`else
                S_CLEAR:    state_q <= S_FETCH;
`endif
                S_FETCH:    if (mem_ready) state_q <= S_ACC;
                S_ACC:      state_q <= i_tc ? S_ACT : S_FETCH;
                S_ACT:      state_q <= S_WRITE;
                S_WRITE:    state_q <= n_tc ? S_DONE : S_CLEAR;
                S_DONE:     state_q <= S_IDLE;
                default:    state_q <= S_IDLE;
            endcase
        end
    end

    // i is cleared on every neuron (re)start; clearing it on abort keeps x_addr clean in the CLEAR that follows.
    // Both counters wrap on their last increment, so they are back at 0 by ACT/DONE respectively.
    assign i_clr = ((state_q == S_IDLE) && start) || (state_q == S_CLEAR) || abort_hit;
    assign i_inc = (state_q == S_ACC);
    assign n_clr = (state_q == S_IDLE) && start;
    assign n_inc = (state_q == S_WRITE);

    wrap_counter #(.MODULUS(N_INPUTS), .W(IW)) u_i_cnt (
        .clk   (clk),
        .rst   (reset),
        .clr_i (i_clr),
        .inc_i (i_inc),
        .cnt_o (i_cnt),
        .tc_o  (i_tc)
    );

    wrap_counter #(.MODULUS(N_NEURONS), .W(NW)) u_n_cnt (
        .clk   (clk),
        .rst   (reset),
        .clr_i (n_clr),
        .inc_i (n_inc),
        .cnt_o (n_cnt),
        .tc_o  (n_tc)
    );

    // Moore decode; addresses are only driven in the states that use them.
    always_comb begin
        ctrl     = CTRL_IDLE;
        w_addr   = '0;
        x_addr   = '0;
        out_addr = '0;
        case (state_q)
            S_CLEAR:    ctrl = CTRL_CLEAR;
`ifdef LAYER_SEQ_BIAS_EN
            S_BIAS: begin
                ctrl   = CTRL_BIAS;
                w_addr = BIAS_BASE + ADDR_W'(n_cnt);
            end
            S_BIAS_ACC: ctrl = CTRL_BIAS_ACC;
`endif
            S_FETCH: begin
                ctrl   = CTRL_FETCH;
                x_addr = i_cnt;
                w_addr = ADDR_W'(n_cnt) * STRIDE + ADDR_W'(i_cnt);
            end
            S_ACC:      ctrl = CTRL_ACC;
            S_ACT:      ctrl = CTRL_ACT;
            S_WRITE: begin
                ctrl     = CTRL_WRITE;
                out_addr = n_cnt;
            end
            S_DONE:     ctrl = CTRL_DONE;
            default:    ctrl = CTRL_IDLE;
        endcase
    end

    assign mem_req  = ctrl.mem_req;
    assign alu_rst  = ctrl.alu_rst;
    assign alu_en   = ctrl.alu_en;
    assign act_en   = ctrl.act_en;
    assign bias_sel = ctrl.bias_sel;
    assign out_we   = ctrl.out_we;
    assign busy     = ctrl.busy;
    assign done     = ctrl.done;

endmodule

// File: tb/tb_layer_sequencer.sv
// Purpose : self-checking bench for layer_sequencer (vector table, directed corner sequences, random vs. step-list model).
// Latency : n/a.
// Backpressure: n/a.
module tb_layer_sequencer;
    localparam int NI = 8;
    localparam int NN = 4;
    localparam int AW = 8;
    localparam int IW = 3;
    localparam int NW = 2;
`ifdef LAYER_SEQ_BIAS_EN
    localparam int BIAS = 1;
`else
    localparam int BIAS = 0;
`endif
    // Edges after the start edge until DONE is entered.
    localparam int PASS_EDGES = NN * (2 * NI + 3 + 2 * BIAS);

    localparam logic [7:0] C_REQ = 8'h80, C_RST = 8'h40, C_EN = 8'h20, C_ACT = 8'h10;
    localparam logic [7:0] C_BS  = 8'h08, C_WE  = 8'h04, C_BUSY = 8'h02, C_DONE = 8'h01;
    localparam logic [20:0] M_CTRL = 21'h1FE000, M_W = 21'h001FE0, M_X = 21'h00001C;
    localparam logic [20:0] M_O = 21'h000003, M_FULL = 21'h1FFFFF;

    logic clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0, mem_ready = 1'b0;
    logic mem_req, alu_rst, alu_en, act_en, bias_sel, out_we, busy, done;
    logic [AW-1:0] w_addr;
    logic [IW-1:0] x_addr;
    logic [NW-1:0] out_addr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    layer_sequencer #(.N_INPUTS(NI), .N_NEURONS(NN), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .mem_ready(mem_ready),
        .mem_req(mem_req), .w_addr(w_addr), .x_addr(x_addr), .alu_rst(alu_rst), .alu_en(alu_en),
        .act_en(act_en), .bias_sel(bias_sel), .out_we(out_we), .out_addr(out_addr),
        .busy(busy), .done(done)
    );

    function automatic logic [20:0] outv();
        return {mem_req, alu_rst, alu_en, act_en, bias_sel, out_we, busy, done, w_addr, x_addr, out_addr};
    endfunction

    function automatic logic [20:0] vec(input logic [7:0] c, input int w, input int x, input int o);
        return {c, 8'(w), 3'(x), 2'(o)};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        start = 1'b0; abort = 1'b0; mem_ready = 1'b0; reset = 1'b1;
        step();
        check("reset_state", 32'(outv()), 32'd0);
        step();
        reset = 1'b0;
    endtask

    // Reference model: a flat list of the steps of one pass; an index walks it.
    typedef struct {
        logic [20:0] exp;
        logic [20:0] mask;
        bit          waits;
        bit          abortable;
        int          restart;
    } step_t;
    step_t prog[$];

    function automatic void add(input logic [20:0] e, input logic [20:0] m, input bit w, input bit ab, input int r);
        step_t s;
        s.exp = e; s.mask = m; s.waits = w; s.abortable = ab; s.restart = r;
        prog.push_back(s);
    endfunction

    function automatic void build_prog();
        int r;
        add(vec(8'h00, 0, 0, 0), M_FULL, 0, 0, 0);
        for (int n = 0; n < NN; n++) begin
            r = prog.size();
            add(vec(C_RST | C_BUSY, 0, 0, 0), M_CTRL, 0, 0, r);
            if (BIAS != 0) begin
                add(vec(C_REQ | C_BS | C_BUSY, NI * NN + n, 0, 0), M_CTRL | M_W, 1, 1, r);
                add(vec(C_EN | C_BS | C_BUSY, 0, 0, 0), M_CTRL, 0, 1, r);
            end
            for (int i = 0; i < NI; i++) begin
                add(vec(C_REQ | C_BUSY, n * NI + i, i, 0), M_CTRL | M_W | M_X, 1, 1, r);
                add(vec(C_EN | C_BUSY, 0, 0, 0), M_CTRL, 0, 1, r);
            end
            add(vec(C_ACT | C_BUSY, 0, 0, 0), M_CTRL, 0, 1, r);
            add(vec(C_WE | C_BUSY, 0, 0, n), M_CTRL | M_O, 0, 0, r);
        end
        add(vec(C_DONE, 0, 0, 0), M_CTRL, 0, 0, 0);
    endfunction

    function automatic int nxt(input int p, input bit s, input bit a, input bit m);
        if (p == 0) return s ? 1 : 0;
        if (prog[p].abortable && a) return prog[p].restart;
        if (prog[p].waits && !m) return p;
        return (p + 1 == prog.size()) ? 0 : p + 1;
    endfunction

    typedef struct {
        bit          s, a, m;
        logic [20:0] exp;
        logic [20:0] mask;
    } row_t;
    row_t tbl[9];

    initial begin : main
        logic [20:0] e_first, m_first, e_first_acc, e_row5, m_row5;
        int edges, wes, dones, stalled, last_w, p;
        bit aborted, seen_restart, seen_we, found, s, a, m;

        build_prog();

        // ---------------- vector table ----------------
        e_first     = BIAS ? vec(C_REQ | C_BS | C_BUSY, NI * NN, 0, 0) : vec(C_REQ | C_BUSY, 0, 0, 0);
        m_first     = BIAS ? (M_CTRL | M_W) : (M_CTRL | M_W | M_X);
        e_first_acc = BIAS ? vec(C_EN | C_BS | C_BUSY, 0, 0, 0) : vec(C_EN | C_BUSY, 0, 0, 0);
        e_row5      = BIAS ? vec(C_REQ | C_BUSY, 0, 0, 0) : vec(C_REQ | C_BUSY, 1, 1, 0);
        m_row5      = M_CTRL | M_W | M_X;
        tbl[0] = '{0, 0, 0, vec(8'h00, 0, 0, 0), M_FULL};      // idle stays idle
        tbl[1] = '{1, 0, 0, vec(C_RST | C_BUSY, 0, 0, 0), M_CTRL}; // start -> CLEAR
        tbl[2] = '{0, 0, 0, e_first, m_first};                  // first request
        tbl[3] = '{0, 0, 0, e_first, m_first};                  // held while mem_ready low
        tbl[4] = '{0, 0, 1, e_first_acc, M_CTRL};               // accumulate
        tbl[5] = '{0, 0, 1, e_row5, m_row5};                    // next fetch
        tbl[6] = '{0, 1, 1, vec(C_RST | C_BUSY, 0, 0, 0), M_CTRL}; // abort beats mem_ready
        tbl[7] = '{1, 0, 1, e_first, m_first};                  // start ignored while busy
        tbl[8] = '{0, 0, 1, e_first_acc, M_CTRL};

        do_reset();
        for (int k = 0; k < 9; k++) begin
            start = tbl[k].s; abort = tbl[k].a; mem_ready = tbl[k].m;
            step();
            check($sformatf("tbl%0d", k), 32'(outv() & tbl[k].mask), 32'(tbl[k].exp & tbl[k].mask));
        end

        // ---------------- full pass, start pulses while busy ----------------
        do_reset();
        mem_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0; edges = 0; wes = 0; dones = 0;
        while (edges < PASS_EDGES + 10) begin
            start = busy && (edges % 7 == 3);
            step();
            edges++;
            if (out_we) begin
                check("out_addr_order", 32'(out_addr), 32'(wes));
                wes++;
            end
            if (done) begin
                dones++;
                if (dones == 1) begin
                    check("done_latency", 32'(edges), 32'(PASS_EDGES));
                    check("busy_at_done", 32'(busy), 32'd0);
                end
            end
        end
        start = 1'b0;
        check("write_count", 32'(wes), 32'(NN));
        check("single_done", 32'(dones), 32'd1);
        check("idle_after_pass", 32'(outv()), 32'd0);

        // ---------------- 3-cycle stall in the first fetch ----------------
        do_reset();
        mem_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0; edges = 0; stalled = 0;
        while (!done && edges < 400) begin
            if (mem_req && !bias_sel && stalled < 3) begin
                check("stall_hold", 32'({mem_req, w_addr}), 32'({1'b1, 8'd0}));
                mem_ready = 1'b0;
                stalled++;
            end else begin
                mem_ready = 1'b1;
            end
            step();
            edges++;
        end
        check("stall_latency", 32'(edges), 32'(PASS_EDGES + 3));

        // ---------------- abort in ACC at n=2, i=5 ----------------
        do_reset();
        mem_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0; edges = 0; last_w = -1;
        aborted = 0; seen_restart = 0; seen_we = 0;
        while (!done && edges < 400) begin
            if (mem_req && !bias_sel) last_w = int'(w_addr);
            abort = !aborted && alu_en && !bias_sel && (last_w == 2 * NI + 5);
            step();
            edges++;
            if (abort) begin
                abort = 1'b0;
                aborted = 1;
                check("abort_to_clear", 32'(outv() & M_CTRL), 32'(vec(C_RST | C_BUSY, 0, 0, 0)));
            end else if (aborted && !seen_restart && mem_req && !bias_sel) begin
                seen_restart = 1;
                check("abort_restart_addr", 32'({x_addr, w_addr}), 32'({3'd0, 8'(2 * NI)}));
            end else if (aborted && !seen_we && out_we) begin
                seen_we = 1;
                check("abort_write_addr", 32'(out_addr), 32'd2);
            end
        end
        abort = 1'b0;
        check("abort_reached_write", 32'(seen_we), 32'd1);
        check("abort_latency", 32'(edges), 32'(PASS_EDGES + 13 + 2 * BIAS));

        // ---------------- asynchronous reset in FETCH with n=1 ----------------
        do_reset();
        mem_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0; edges = 0;
        while (!(mem_req && !bias_sel && w_addr == 8'(NI)) && edges < 200) begin
            step();
            edges++;
        end
        found = (edges < 200);
        check("reach_fetch_n1", 32'(found), 32'd1);
        #2 reset = 1'b1;
        #1 check("async_reset_outputs", 32'(outv()), 32'd0);
        #1 reset = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0; edges = 0;
        while (!(mem_req && !bias_sel) && edges < 50) begin
            step();
            edges++;
        end
        check("restart_w_addr", 32'({mem_req, w_addr}), 32'({1'b1, 8'd0}));

        // ---------------- random stimulus vs. step-list model ----------------
        do_reset();
        p = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            s = ($urandom_range(0, 3) == 0);
            a = ($urandom_range(0, 79) == 0);
            m = ($urandom_range(0, 3) != 0);
            start = s; abort = a; mem_ready = m;
            if ($urandom_range(0, 399) == 0) begin
                #2 reset = 1'b1;
                #1 check("rand_async_reset", 32'(outv()), 32'd0);
                p = 0;
                #1 reset = 1'b0;
            end
            @(posedge clk);
            p = nxt(p, s, a, m);
            #1;
            check($sformatf("rand_cyc%0d", cyc), 32'(outv() & prog[p].mask), 32'(prog[p].exp & prog[p].mask));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
